// File: rtl/sfx_scheduler_pkg.sv
// Shared game encodings for the sound-effect scheduler: game states, effect ids, FSM states.
// Also holds the fixed-priority pick used to choose among queued effect requests.
package sfx_scheduler_pkg;

    typedef enum logic [2:0] {
        GS_INIT = 3'd0,
        GS_WAIT = 3'd1,
        GS_GAME = 3'd2,
        GS_WIN  = 3'd3,
        GS_LOSE = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        SFX_STAR = 2'd0,
        SFX_HIT  = 2'd1,
        SFX_WIN  = 2'd2,
        SFX_LOSE = 2'd3
    } sfx_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } fsm_e;

    // LOSE > WIN > HIT > STAR; returns STAR when nothing is set, so callers gate on |p.
    function automatic logic [1:0] prio_pick(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Request/status bundle between game logic and the effect scheduler.
// master drives requests and game context, slave reports the active effect.
interface sfx_scheduler_if;
    logic       tick;
    logic [2:0] game_state;
    logic [3:0] req;
    logic       mute;
    logic [1:0] sfx_id;
    logic [3:0] step;
    logic       sfx_on;
    logic       bgm_pause;
    logic       grant;
    logic [3:0] pending;

    modport master (
        output tick, game_state, req, mute,
        input  sfx_id, step, sfx_on, bgm_pause, grant, pending
    );

    modport slave (
        input  tick, game_state, req, mute,
        output sfx_id, step, sfx_on, bgm_pause, grant, pending
    );
endinterface

// File: rtl/sfx_scheduler.sv
// Queues effect requests and plays one at a time over background music, jingles preempting STAR/HIT.
// All outputs registered; a queued request is dispatched one clock after it becomes pending.
module sfx_scheduler
    import sfx_scheduler_pkg::*;
#(
    parameter int STAR_LEN   = 4,
    parameter int HIT_LEN    = 3,
    parameter int JINGLE_LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    sfx_scheduler_if.slave bus
);

    localparam logic [3:0] STAR_LAST   = 4'(STAR_LEN - 1);
    localparam logic [3:0] HIT_LAST    = 4'(HIT_LEN - 1);
    localparam logic [3:0] JINGLE_LAST = 4'(JINGLE_LEN - 1);

    fsm_e       state, state_nxt;
    logic [1:0] id_q, id_nxt;
    logic [3:0] step_q, step_nxt;
    logic [3:0] pending_q, pending_nxt;
    logic       grant_q, grant_nxt;
    logic       sfx_on_q, bgm_pause_q;
    logic [2:0] gs_prev_q;

    logic [3:0] set, clr, avail;
    logic [1:0] winner;
    logic       flush, in_menu, was_menu;

    function automatic logic [3:0] last_step(input logic [1:0] id);
        case (id)
            2'd0:    return STAR_LAST;
            2'd1:    return HIT_LAST;
            default: return JINGLE_LAST;
        endcase
    endfunction

    assign in_menu  = (bus.game_state == GS_INIT) || (bus.game_state == GS_WAIT);
    assign was_menu = (gs_prev_q == GS_INIT) || (gs_prev_q == GS_WAIT);
    assign flush    = in_menu && !was_menu;

    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        step_nxt  = step_q;
        grant_nxt = 1'b0;
        set       = bus.mute ? 4'b0000 : bus.req;
        clr       = 4'b0000;
        avail     = pending_q;
        winner    = 2'd0;

        if (bus.mute) begin
            state_nxt = S_IDLE;
            clr       = 4'b1111;
        end else begin
            if (flush) clr = 4'b0011;
            // Requests flushed this edge must not be dispatched on the same edge.
            avail  = pending_q & ~clr;
            winner = prio_pick(avail);
            case (state)
                S_IDLE: begin
                    if (|avail) begin
                        state_nxt = S_PLAY;
                        id_nxt    = winner;
                        step_nxt  = 4'd0;
                        grant_nxt = 1'b1;
                        clr       = clr | (4'b0001 << winner);
                    end
                end
                S_PLAY: begin
                    if (flush && !id_q[1]) begin
                        state_nxt = S_IDLE;
                    end else if (!id_q[1] && (avail[3] || avail[2])) begin
                        // Preempted STAR/HIT is dropped, not requeued.
                        id_nxt    = winner;
                        step_nxt  = 4'd0;
                        grant_nxt = 1'b1;
                        clr       = clr | (4'b0001 << winner);
                    end else if (bus.tick) begin
                        if (step_q == last_step(id_q)) begin
                            state_nxt = S_GAP;
                            step_nxt  = 4'd0;
                        end else begin
                            step_nxt = step_q + 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.tick) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // Set wins over a same-cycle clear.
        pending_nxt = (pending_q & ~clr) | set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            id_q        <= 2'd0;
            step_q      <= 4'd0;
            pending_q   <= 4'd0;
            grant_q     <= 1'b0;
            sfx_on_q    <= 1'b0;
            bgm_pause_q <= 1'b0;
            gs_prev_q   <= GS_INIT;
        end else begin
            state       <= state_nxt;
            id_q        <= id_nxt;
            step_q      <= step_nxt;
            pending_q   <= pending_nxt;
            grant_q     <= grant_nxt;
            sfx_on_q    <= (state_nxt == S_PLAY);
            bgm_pause_q <= (state_nxt == S_PLAY) || (state_nxt == S_GAP);
            gs_prev_q   <= bus.game_state;
        end
    end

    assign bus.sfx_id    = id_q;
    assign bus.step      = step_q;
    assign bus.sfx_on    = sfx_on_q;
    assign bus.bgm_pause = bgm_pause_q;
    assign bus.grant     = grant_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scenario bench for sfx_scheduler: expected grants queued at stimulus time, popped on each observed grant.
module tb_sfx_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [1:0] exp_q[$];

    sfx_scheduler_if bus();

    sfx_scheduler #(.STAR_LEN(4), .HIT_LEN(3), .JINGLE_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
    endtask

    // Grant monitor: every grant must match the oldest expected effect id.
    always @(posedge clk) begin
        #1;
        if (bus.grant === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got grant for sfx_id=%0d, expected no grant", bus.sfx_id);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (bus.sfx_id !== e) begin
                    errors++;
                    $display("FAIL grant_id: got sfx_id=%0d, expected %0d", bus.sfx_id, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        checks++; if (bus.sfx_id !== 2'd0)     begin errors++; $display("FAIL reset_sfx_id: got %0d, expected 0", bus.sfx_id); end
        checks++; if (bus.step !== 4'd0)       begin errors++; $display("FAIL reset_step: got %0d, expected 0", bus.step); end
        checks++; if (bus.sfx_on !== 1'b0)     begin errors++; $display("FAIL reset_sfx_on: got %b, expected 0", bus.sfx_on); end
        checks++; if (bus.bgm_pause !== 1'b0)  begin errors++; $display("FAIL reset_bgm_pause: got %b, expected 0", bus.bgm_pause); end
        checks++; if (bus.grant !== 1'b0)      begin errors++; $display("FAIL reset_grant: got %b, expected 0", bus.grant); end
        checks++; if (bus.pending !== 4'd0)    begin errors++; $display("FAIL reset_pending: got %b, expected 0000", bus.pending); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_star();
        bus.req = 4'b0001;
        cyc();
        bus.req = 4'b0000;
        checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL star_pending: got %b, expected 0001", bus.pending); end
        checks++; if (bus.sfx_on !== 1'b0)     begin errors++; $display("FAIL star_not_yet: got sfx_on=%b, expected 0", bus.sfx_on); end
        exp_q.push_back(2'd0);
        cyc();
        checks++; if (bus.grant !== 1'b1)      begin errors++; $display("FAIL star_grant: got %b, expected 1", bus.grant); end
        checks++; if (bus.sfx_on !== 1'b1 || bus.bgm_pause !== 1'b1) begin errors++; $display("FAIL star_play: got sfx_on=%b bgm_pause=%b, expected 1 1", bus.sfx_on, bus.bgm_pause); end
        checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL star_pending_clr: got %b, expected 0000", bus.pending); end
        do_tick(); do_tick();
        checks++; if (bus.step !== 4'd2 || bus.grant !== 1'b0) begin errors++; $display("FAIL star_step2: got step=%0d grant=%b, expected 2 0", bus.step, bus.grant); end
        do_tick(); do_tick();
        checks++; if (bus.sfx_on !== 1'b0 || bus.bgm_pause !== 1'b1 || bus.step !== 4'd0) begin errors++; $display("FAIL star_gap: got sfx_on=%b bgm_pause=%b step=%0d, expected 0 1 0", bus.sfx_on, bus.bgm_pause, bus.step); end
        do_tick();
        checks++; if (bus.bgm_pause !== 1'b0 || bus.sfx_on !== 1'b0) begin errors++; $display("FAIL star_idle: got bgm_pause=%b sfx_on=%b, expected 0 0", bus.bgm_pause, bus.sfx_on); end
    endtask

    task automatic test_priority();
        bus.req = 4'b0011;
        cyc();
        bus.req = 4'b0000;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        cyc();
        checks++; if (bus.sfx_id !== 2'd1 || bus.pending !== 4'b0001) begin errors++; $display("FAIL prio_hit_first: got sfx_id=%0d pending=%b, expected 1 0001", bus.sfx_id, bus.pending); end
        do_tick(); do_tick(); do_tick();
        checks++; if (bus.sfx_on !== 1'b0 || bus.pending !== 4'b0001) begin errors++; $display("FAIL prio_gap: got sfx_on=%b pending=%b, expected 0 0001", bus.sfx_on, bus.pending); end
        do_tick();
        checks++; if (bus.sfx_id !== 2'd0 || bus.sfx_on !== 1'b1 || bus.pending !== 4'b0000) begin errors++; $display("FAIL prio_star_next: got sfx_id=%0d sfx_on=%b pending=%b, expected 0 1 0000", bus.sfx_id, bus.sfx_on, bus.pending); end
        for (int i = 0; i < 5; i++) do_tick();
    endtask

    task automatic test_preempt();
        bus.req = 4'b0001;
        cyc();
        bus.req = 4'b0000;
        exp_q.push_back(2'd0);
        cyc();
        do_tick(); do_tick();
        checks++; if (bus.step !== 4'd2) begin errors++; $display("FAIL preempt_step2: got %0d, expected 2", bus.step); end
        bus.req = 4'b1000;
        exp_q.push_back(2'd3);
        cyc();
        bus.req = 4'b0000;
        checks++; if (bus.pending !== 4'b1000 || bus.sfx_id !== 2'd0) begin errors++; $display("FAIL preempt_queued: got pending=%b sfx_id=%0d, expected 1000 0", bus.pending, bus.sfx_id); end
        cyc();
        checks++; if (bus.sfx_id !== 2'd3 || bus.step !== 4'd0 || bus.grant !== 1'b1) begin errors++; $display("FAIL preempt_lose: got sfx_id=%0d step=%0d grant=%b, expected 3 0 1", bus.sfx_id, bus.step, bus.grant); end
        for (int i = 0; i < 9; i++) do_tick();
        cyc();
        checks++; if (bus.sfx_on !== 1'b0 || bus.pending !== 4'b0000) begin errors++; $display("FAIL preempt_no_replay: got sfx_on=%b pending=%b, expected 0 0000", bus.sfx_on, bus.pending); end
    endtask

    task automatic test_coalesce();
        bus.req = 4'b1000;
        cyc();
        bus.req = 4'b0000;
        exp_q.push_back(2'd3);
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.req = 4'b0001;
            cyc();
            bus.req = 4'b0000;
            do_tick();
        end
        checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL coalesce_pending: got %b, expected 0001", bus.pending); end
        checks++; if (bus.sfx_id !== 2'd3 || bus.step !== 4'd3) begin errors++; $display("FAIL coalesce_jingle: got sfx_id=%0d step=%0d, expected 3 3", bus.sfx_id, bus.step); end
        for (int i = 0; i < 4; i++) do_tick();
        checks++; if (bus.sfx_on !== 1'b1 || bus.step !== 4'd7) begin errors++; $display("FAIL coalesce_step7: got sfx_on=%b step=%0d, expected 1 7", bus.sfx_on, bus.step); end
        do_tick();
        checks++; if (bus.sfx_on !== 1'b0 || bus.bgm_pause !== 1'b1) begin errors++; $display("FAIL coalesce_gap: got sfx_on=%b bgm_pause=%b, expected 0 1", bus.sfx_on, bus.bgm_pause); end
        exp_q.push_back(2'd0);
        do_tick();
        checks++; if (bus.sfx_id !== 2'd0 || bus.sfx_on !== 1'b1 || bus.pending !== 4'b0000) begin errors++; $display("FAIL coalesce_star_once: got sfx_id=%0d sfx_on=%b pending=%b, expected 0 1 0000", bus.sfx_id, bus.sfx_on, bus.pending); end
        for (int i = 0; i < 5; i++) do_tick();
    endtask

    task automatic test_flush_and_mute();
        bus.game_state = 3'd2;
        bus.req = 4'b0010;
        cyc();
        bus.req = 4'b0000;
        exp_q.push_back(2'd1);
        cyc();
        do_tick();
        bus.req = 4'b0001;
        cyc();
        bus.game_state = 3'd1;
        bus.req = 4'b0100;
        cyc();
        bus.req = 4'b0000;
        checks++; if (bus.sfx_on !== 1'b0 || bus.bgm_pause !== 1'b0 || bus.pending !== 4'b0100) begin errors++; $display("FAIL flush_abort: got sfx_on=%b bgm_pause=%b pending=%b, expected 0 0 0100", bus.sfx_on, bus.bgm_pause, bus.pending); end
        exp_q.push_back(2'd2);
        cyc();
        checks++; if (bus.sfx_id !== 2'd2 || bus.sfx_on !== 1'b1) begin errors++; $display("FAIL flush_win_kept: got sfx_id=%0d sfx_on=%b, expected 2 1", bus.sfx_id, bus.sfx_on); end
        do_tick(); do_tick();
        bus.game_state = 3'd2;
        cyc();
        bus.game_state = 3'd0;
        bus.req = 4'b0001;
        cyc();
        bus.req = 4'b0000;
        cyc();
        checks++; if (bus.sfx_on !== 1'b1 || bus.step !== 4'd2 || bus.pending !== 4'b0001) begin errors++; $display("FAIL flush_jingle_kept: got sfx_on=%b step=%0d pending=%b, expected 1 2 0001", bus.sfx_on, bus.step, bus.pending); end
        bus.mute = 1'b1;
        cyc();
        checks++; if (bus.sfx_on !== 1'b0 || bus.bgm_pause !== 1'b0 || bus.pending !== 4'b0000) begin errors++; $display("FAIL mute_abort: got sfx_on=%b bgm_pause=%b pending=%b, expected 0 0 0000", bus.sfx_on, bus.bgm_pause, bus.pending); end
        bus.req = 4'b1001;
        cyc();
        bus.req = 4'b0000;
        cyc();
        checks++; if (bus.pending !== 4'b0000 || bus.sfx_on !== 1'b0) begin errors++; $display("FAIL mute_discard: got pending=%b sfx_on=%b, expected 0000 0", bus.pending, bus.sfx_on); end
        bus.mute = 1'b0;
        bus.game_state = 3'd2;
        cyc();
    endtask

    task automatic test_reset_mid_play();
        bus.req = 4'b0010;
        cyc();
        bus.req = 4'b0000;
        exp_q.push_back(2'd1);
        cyc();
        do_tick();
        checks++; if (bus.step !== 4'd1 || bus.sfx_id !== 2'd1) begin errors++; $display("FAIL rst_pre: got step=%0d sfx_id=%0d, expected 1 1", bus.step, bus.sfx_id); end
        rst = 1'b1;
        bus.req = 4'b0001;
        cyc();
        bus.req = 4'b0000;
        checks++; if (bus.sfx_id !== 2'd0 || bus.step !== 4'd0 || bus.sfx_on !== 1'b0 || bus.bgm_pause !== 1'b0 || bus.grant !== 1'b0 || bus.pending !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_play: got sfx_id=%0d step=%0d sfx_on=%b bgm_pause=%b grant=%b pending=%b, expected all zero",
                     bus.sfx_id, bus.step, bus.sfx_on, bus.bgm_pause, bus.grant, bus.pending);
        end
        rst = 1'b0;
        cyc(); cyc();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.tick       = 1'b0;
        bus.game_state = 3'd2;
        bus.req        = 4'b0000;
        bus.mute       = 1'b0;

        test_reset();
        test_star();
        test_priority();
        test_preempt();
        test_coalesce();
        test_flush_and_mute();
        test_reset_mid_play();

        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grants_outstanding: got %0d ungranted effects, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 SHALL have parameter STAR_LEN, default 4, star-collect effect length in ticks.
REQ-002 SHALL have parameter HIT_LEN, default 3, damage effect length in ticks.
REQ-003 SHALL have parameter JINGLE_LEN, default 8, win/lose jingle length in ticks.
REQ-004 SHALL have ports: clk  input  1  system clock, sole clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports: tick  input  1  one-cycle note-step enable; game_state  input  3  top-level game state (INIT/WAIT/GAME/WIN/LOSE).
REQ-006 SHALL have ports: req  input  4  one-cycle effect requests, bit0 STAR, bit1 HIT, bit2 WIN, bit3 LOSE; mute  input  1  volume-zero flag.
REQ-007 SHALL have ports: sfx_id  output  2  active effect (0 STAR, 1 HIT, 2 WIN, 3 LOSE); step  output  4  note index within the active effect.
REQ-008 SHALL have ports: sfx_on  output  1  effect is driving audio; bgm_pause  output  1  background music muted; grant  output  1  one-cycle pulse at effect start; pending  output  4  queued requests.

Function
REQ-009 SHALL implement FSM states IDLE (background music), PLAY (effect active) and GAP (one-tick silence after an effect).
REQ-010 SHALL set pending[i] on the clock edge after req[i]=1 while mute=0; requests with mute=1 SHALL be discarded.
REQ-011 SHALL coalesce duplicate requests: a req bit whose pending bit is already set SHALL leave it set, with no count kept.
REQ-012 SHALL keep a pending bit set when its set and clear occur in the same cycle (set wins).
REQ-013 SHALL use fixed priority LOSE > WIN > HIT > STAR when selecting among pending bits.
REQ-014 In IDLE with any pending bit set, SHALL go to PLAY next clock: load sfx_id with the winner, step=0, clear that pending bit, grant=1 for exactly that cycle.
REQ-015 In PLAY, SHALL increment step on tick; on tick with step = LEN(sfx_id)-1, SHALL go to GAP with step=0.
REQ-016 In GAP, SHALL return to IDLE on the next tick; pending bits remain queued.
REQ-017 In PLAY with sfx_id STAR or HIT and pending WIN or LOSE set, SHALL restart PLAY next clock with the jingle (step=0, grant=1); the preempted effect SHALL be dropped, not re-queued.
REQ-018 SHALL NOT preempt: STAR by HIT, HIT by STAR, or any jingle by any request; those requests stay pending.
REQ-019 SHALL abort PLAY/GAP to IDLE on the clock after mute rises, and SHALL clear all pending bits.
REQ-020 When game_state enters INIT or WAIT, SHALL clear pending STAR/HIT next clock and abort a STAR/HIT effect to IDLE; WIN/LOSE pending and jingles SHALL be retained.
REQ-021 SHALL drive sfx_on=1 only in PLAY; bgm_pause=1 in PLAY and GAP; sfx_id and step SHALL hold their last values outside PLAY.
REQ-022 SHALL ignore tick in IDLE; a tick coinciding with dispatch SHALL NOT advance the new effect (step stays 0).
REQ-023 SHALL register all outputs; step width 4 supports LEN values up to 16.

Reset
REQ-024 On rst=1 at a clk edge, SHALL enter IDLE with sfx_id=0, step=0, sfx_on=0, bgm_pause=0, grant=0, pending=0, overriding all other inputs, including mid-effect.

Structure
REQ-025 SHALL take game-state encodings (INIT 0, WAIT 1, GAME 2, WIN 3, LOSE 4), sfx_id codes and FSM state encodings from the shared game package.
REQ-026 SHALL be a single module; the priority encoder MAY be a function in the shared package, with no sub-module required.

Verification
REQ-027 req=0001 in IDLE -> pending=0001 after one clock, then grant, sfx_id=0, PLAY; 4 ticks -> GAP; 1 tick -> IDLE, bgm_pause=0.
REQ-028 req=0011 in the same cycle -> HIT plays first, STAR stays pending; after HIT, GAP and IDLE, STAR is granted.
REQ-029 STAR at step 2, then req=1000 -> next clock sfx_id=3, step=0, grant=1; STAR is not replayed after the jingle.
REQ-030 During a LOSE jingle, req=0001 three times -> pending=0001 single bit; the jingle runs all 8 ticks uninterrupted.
REQ-031 During HIT, game_state goes GAME->WAIT -> next clock IDLE, pending STAR/HIT cleared; WIN pending preserved.
REQ-032 mute=1 mid-jingle -> IDLE next clock, pending=0; req while muted -> pending stays 0; rst mid-PLAY -> all outputs reset.
